// File: rtl/fifo_rx_pkg.sv
// Shared widths and thresholds for the phy receive path, plus the FIFO
// operation encoding used by the receive buffer.
package fifo_rx_pkg;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int ADDR_W    = 3;
  localparam int AF_THRESH = 6;
  localparam int AE_THRESH = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr_fire, input logic rd_fire);
    return fifo_op_e'({wr_fire, rd_fire});
  endfunction

endpackage : fifo_rx_pkg

// File: rtl/mem_rx_phy.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read.
module mem_rx_phy #(
  parameter int DATA_W = fifo_rx_pkg::DATA_W,
  parameter int DEPTH  = fifo_rx_pkg::DEPTH,
  parameter int ADDR_W = fifo_rx_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the FIFO pointers and count decide what is
  // valid, so clearing the array would only cost a reset tree for nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : mem_rx_phy

// File: rtl/fifo_rx_phy.sv
// Receive-side word buffer behind the phy: captures validIn words and hands
// them to the consumer on rd_en with a registered, one-cycle-latency output.
module fifo_rx_phy #(
  parameter int DATA_W    = fifo_rx_pkg::DATA_W,
  parameter int DEPTH     = fifo_rx_pkg::DEPTH,
  parameter int ADDR_W    = fifo_rx_pkg::ADDR_W,
  parameter int AF_THRESH = fifo_rx_pkg::AF_THRESH,
  parameter int AE_THRESH = fifo_rx_pkg::AE_THRESH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   count
);

  import fifo_rx_pkg::*;

  localparam logic [ADDR_W:0]   FULL_LVL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   AF_LVL   = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0]   AE_LVL   = AE_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_data;
  fifo_op_e          op;

  mem_rx_phy #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr_q),
    .wdata (dataIn),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign full         = (count_q == FULL_LVL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);

  // A read frees the slot a full-FIFO write needs in the same edge; the
  // async read returns the old word before the write lands on it.
  assign rd_fire = rd_en && !empty;
  assign wr_fire = validIn && (!full || rd_fire);
  assign op      = fifo_op(wr_fire, rd_fire);

  // NOTE: every always_comb output gets a default first so no path leaves
  // one unassigned and infers a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    overflow_d  = overflow_q | (validIn && !wr_fire);
    underflow_d = underflow_q | (rd_en && empty);

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_fire) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      data_out_d  = rd_data;
      valid_out_d = 1'b1;
    end

    unique case (op)
      OP_WR:   count_d = count_q + CNT_ONE;
      OP_RD:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign dataOut   = data_out_q;
  assign validOut  = valid_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign count     = count_q;

endmodule : fifo_rx_phy

// File: tb/tb_fifo_rx_phy.sv
// Directed bench for fifo_rx_phy: fill/drain, overflow, wrap under
// simultaneous traffic, underflow with write, full read+write, async reset.
module tb_fifo_rx_phy;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              validIn;
  logic [DATA_W-1:0] dataIn;
  logic              rd_en;
  logic [DATA_W-1:0] dataOut;
  logic              validOut;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  logic [ADDR_W:0]   count;

  int checks   = 0;
  int failures = 0;

  fifo_rx_phy dut (
    .clk          (clk),
    .reset        (reset),
    .validIn      (validIn),
    .dataIn       (dataIn),
    .rd_en        (rd_en),
    .dataOut      (dataOut),
    .validOut     (validOut),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [ADDR_W:0] exp_cnt);
    check({tag, ".count"}, DATA_W'(count), DATA_W'(exp_cnt));
    check({tag, ".full"}, DATA_W'(full), DATA_W'(exp_cnt == 4'd8));
    check({tag, ".empty"}, DATA_W'(empty), DATA_W'(exp_cnt == 4'd0));
    check({tag, ".almost_full"}, DATA_W'(almost_full), DATA_W'(exp_cnt >= 4'd6));
    check({tag, ".almost_empty"}, DATA_W'(almost_empty), DATA_W'(exp_cnt <= 4'd2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    validIn = 1'b0;
    dataIn  = '0;
    rd_en   = 1'b0;
    tick();
    tick();

    // Reset state
    check_flags("reset", 4'd0);
    check("reset.dataOut", dataOut, 32'h0);
    check("reset.validOut", DATA_W'(validOut), 32'd0);
    check("reset.overflow", DATA_W'(overflow), 32'd0);
    check("reset.underflow", DATA_W'(underflow), 32'd0);
    reset = 1'b0;

    // Fill with 8 words, no reads
    for (int i = 0; i < 8; i++) begin
      validIn = 1'b1;
      dataIn  = 32'hA000_0000 + 32'(i);
      tick();
      check_flags("fill", 4'(i + 1));
      check("fill.overflow", DATA_W'(overflow), 32'd0);
    end

    // Write while full is dropped, overflow sticky
    dataIn = 32'hDEAD_BEEF;
    tick();
    validIn = 1'b0;
    check_flags("ovf", 4'd8);
    check("ovf.overflow", DATA_W'(overflow), 32'd1);
    tick();
    check("ovf.overflow_hold", DATA_W'(overflow), 32'd1);

    // Drain 8 words in order, each with a 1-cycle validOut
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      check("drain.validOut", DATA_W'(validOut), 32'd1);
      check("drain.dataOut", dataOut, 32'hA000_0000 + 32'(i));
      check("drain.count", DATA_W'(count), 32'(7 - i));
    end
    rd_en = 1'b0;
    tick();
    check("drain.validOut_low", DATA_W'(validOut), 32'd0);
    check("drain.dataOut_hold", dataOut, 32'hA000_0007);
    check_flags("drain_end", 4'd0);
    check("drain.overflow_sticky", DATA_W'(overflow), 32'd1);

    // Prefill 4 words, then 10 cycles of simultaneous read+write across the wrap
    validIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dataIn = 32'hB000_0000 + 32'(i);
      tick();
    end
    check_flags("prefill", 4'd4);
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dataIn = 32'hB000_0004 + 32'(i);
      tick();
      check("stream.count", DATA_W'(count), 32'd4);
      check("stream.validOut", DATA_W'(validOut), 32'd1);
      check("stream.dataOut", dataOut, 32'hB000_0000 + 32'(i));
    end
    validIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tail.dataOut", dataOut, 32'hB000_000A + 32'(i));
    end
    rd_en = 1'b0;
    tick();
    check_flags("tail_end", 4'd0);

    // Read on empty with same-cycle write: underflow, no fall-through
    validIn = 1'b1;
    rd_en   = 1'b1;
    dataIn  = 32'h1234_5678;
    tick();
    validIn = 1'b0;
    check("udf.underflow", DATA_W'(underflow), 32'd1);
    check("udf.validOut", DATA_W'(validOut), 32'd0);
    check("udf.dataOut_hold", dataOut, 32'hB000_000D);
    check_flags("udf", 4'd1);
    tick();
    rd_en = 1'b0;
    check("udf.next_valid", DATA_W'(validOut), 32'd1);
    check("udf.next_data", dataOut, 32'h1234_5678);
    check("udf.underflow_sticky", DATA_W'(underflow), 32'd1);
    check_flags("udf_next", 4'd0);

    // Clear sticky flags, fill, then read+write while full
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("clr.overflow", DATA_W'(overflow), 32'd0);
    check("clr.underflow", DATA_W'(underflow), 32'd0);
    validIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dataIn = 32'hC000_0000 + 32'(i);
      tick();
    end
    check_flags("full2", 4'd8);
    rd_en  = 1'b1;
    dataIn = 32'h55AA_55AA;
    tick();
    validIn = 1'b0;
    check_flags("fullrw", 4'd8);
    check("fullrw.overflow", DATA_W'(overflow), 32'd0);
    check("fullrw.dataOut", dataOut, 32'hC000_0000);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("fullrw.drain", dataOut, 32'hC000_0000 + 32'(i));
    end
    tick();
    check("fullrw.last", dataOut, 32'h55AA_55AA);
    check("fullrw.last_valid", DATA_W'(validOut), 32'd1);
    rd_en = 1'b0;
    check_flags("fullrw_end", 4'd0);

    // Build count=5 with a live read and sticky underflow, then async reset
    rd_en = 1'b1;
    tick();
    check("pre.underflow", DATA_W'(underflow), 32'd1);
    rd_en   = 1'b0;
    validIn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dataIn = 32'hD000_0000 + 32'(i);
      tick();
    end
    validIn = 1'b0;
    rd_en   = 1'b1;
    tick();
    rd_en = 1'b0;
    check_flags("pre", 4'd5);
    check("pre.validOut", DATA_W'(validOut), 32'd1);
    check("pre.dataOut", dataOut, 32'hD000_0000);
    #2;
    reset = 1'b1;
    #1;
    check_flags("async", 4'd0);
    check("async.validOut", DATA_W'(validOut), 32'd0);
    check("async.dataOut", dataOut, 32'h0);
    check("async.overflow", DATA_W'(overflow), 32'd0);
    check("async.underflow", DATA_W'(underflow), 32'd0);
    #1;
    reset = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post.underflow", DATA_W'(underflow), 32'd1);
    check("post.validOut", DATA_W'(validOut), 32'd0);
    check_flags("post", 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_rx_phy
